// File: rtl/flt_pds2_onboard_checker_if.sv
// AXI4-Stream result channel from flt_pds2 into the onboard checker.
interface flt_pds2_onboard_checker_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/flt_pds2_onboard_checker.sv
// Sink end of the flt_pds2 onboard harness: accepts results, compares each beat
// against a golden ROM word and keeps pass/fail, first-failure index and a
// no-progress watchdog for on-board readout. tready follows a rotating stall mask.
module flt_pds2_onboard_checker #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    EXP_WIDTH      = 8,
  parameter int                    MAN_WIDTH      = 23,
  parameter int                    ADDR_WIDTH     = 5,
  parameter int                    NUM_VECTORS    = 32,
  parameter logic [DATA_WIDTH-1:0] CMP_MASK       = '1,
  parameter int                    NAN_AWARE      = 1,
  parameter logic [7:0]            TREADY_PATTERN = 8'hFF,
  parameter int                    TIMEOUT_CYCLES = 1024,
  parameter int                    ERR_CNT_WIDTH  = 8
) (
  input  logic                         i_aclk,
  input  logic                         i_areset,
  input  logic                         i_start,
  flt_pds2_onboard_checker_if.slave    axi4s_result,
  output logic [ADDR_WIDTH-1:0]        o_exp_rd_addr,
  input  logic [DATA_WIDTH-1:0]        i_exp_rd_data,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_pass,
  output logic                         o_timeout,
  output logic [ERR_CNT_WIDTH-1:0]     o_err_cnt,
  output logic [ADDR_WIDTH-1:0]        o_first_err_idx
);

  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(NUM_VECTORS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t                   state, state_nxt;
  logic [ADDR_WIDTH-1:0]    idx;
  logic [7:0]               pattern;
  logic [WD_W-1:0]          wdog;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  logic [ADDR_WIDTH-1:0]    first_err_idx;
  logic                     pass_q;
  logic                     timeout_q;

  logic                     tready_c;
  logic                     busy_c;
  logic                     done_c;
  logic [ADDR_WIDTH-1:0]    rd_addr_c;
  logic                     beat;
  logic                     last_beat;
  logic                     wd_expire;
  logic                     arm_entry;
  logic                     mismatch;

  // NaN: exponent all ones with a non-zero mantissa, judged on the unmasked word.
  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] w);
    return (&w[MAN_WIDTH +: EXP_WIDTH]) && (|w[MAN_WIDTH-1:0]);
  endfunction

  function automatic logic words_match(input logic [DATA_WIDTH-1:0] a,
                                       input logic [DATA_WIDTH-1:0] e);
    return ((a & CMP_MASK) == (e & CMP_MASK)) ||
           ((NAN_AWARE != 0) && is_nan(a) && is_nan(e));
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign mismatch = beat && !words_match(axi4s_result.tdata, i_exp_rd_data);

  // State register.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state, handshake and ROM address; the address looks one word ahead on a
  // beat so the synchronous ROM always presents the word for the current idx.
  always_comb begin
    state_nxt = state;
    tready_c  = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    rd_addr_c = '0;
    beat      = 1'b0;
    last_beat = 1'b0;
    wd_expire = 1'b0;
    arm_entry = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          state_nxt = S_ARM;
          arm_entry = 1'b1;
        end
      end
      S_ARM: begin
        busy_c    = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        busy_c    = 1'b1;
        tready_c  = pattern[0];
        beat      = axi4s_result.tvalid && pattern[0];
        rd_addr_c = beat ? idx + 1'b1 : idx;
        if (beat && (idx == IDX_LAST)) begin
          last_beat = 1'b1;
          state_nxt = S_DONE;
        end else if (!beat && (wdog == WD_LAST)) begin
          wd_expire = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done_c = 1'b1;
        if (i_start) begin
          state_nxt = S_ARM;
          arm_entry = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Run bookkeeping: beat index, stall pattern, watchdog and accumulated status.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      idx           <= '0;
      pattern       <= TREADY_PATTERN;
      wdog          <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else if (arm_entry) begin
      idx           <= '0;
      pattern       <= TREADY_PATTERN;
      wdog          <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else if (state == S_RUN) begin
      pattern <= {pattern[6:0], pattern[7]};
      if (beat) begin
        idx  <= idx + 1'b1;
        wdog <= '0;
      end else begin
        wdog <= wdog + 1'b1;
      end
      if (mismatch) begin
        err_cnt <= sat_inc(err_cnt);
        if (err_cnt == '0) first_err_idx <= idx;
      end
      if (last_beat) pass_q <= (err_cnt == '0) && !mismatch;
      if (wd_expire) begin
        timeout_q <= 1'b1;
        pass_q    <= 1'b0;
      end
    end
  end

  assign axi4s_result.tready = tready_c;
  assign o_exp_rd_addr       = rd_addr_c;
  assign o_busy              = busy_c;
  assign o_done              = done_c;
  assign o_pass              = pass_q;
  assign o_timeout           = timeout_q;
  assign o_err_cnt           = err_cnt;
  assign o_first_err_idx     = first_err_idx;

endmodule
